// File: rtl/p16_uart_serializer.sv
// rtl/p16_uart_serializer.sv - UART transmit serializer with a 2-entry input buffer.
module p16_uart_serializer #(
    parameter int CLK_FREQ  = 250000,
    parameter int BAUD      = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_out,
    output logic       o_busy
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "p16_uart_serializer: CLK_FREQ/BAUD must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $fatal(1, "p16_uart_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "p16_uart_serializer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic            r_stop_idx;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_out;
    logic            r_ready;
    logic [7:0]      r_buf0;
    logic [7:0]      r_buf1;
    logic [1:0]      r_count;

    logic            w_bit_end;
    logic            w_last_stop;
    logic            w_pop;
    logic            w_push;
    logic            w_head_par;
    logic [1:0]      w_count_next;

    assign w_bit_end   = (r_cnt == '0);
    assign w_last_stop = (STOP_BITS == 2) ? r_stop_idx : 1'b1;
    assign w_push      = i_valid && r_ready;
    assign w_pop       = (r_count != 2'd0) &&
                         ((r_state == S_IDLE) ||
                          (r_state == S_STOP && w_bit_end && w_last_stop));
    assign w_head_par  = (PARITY == 2) ? ~(^r_buf0) : ^r_buf0;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 2'd1;
        end
    end

    // Buffer head lives in r_buf0; a push during a pop lands behind whatever remains.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf0  <= 8'h00;
            r_buf1  <= 8'h00;
            r_count <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next < 2'd2);
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf0 <= i_data;
                    end else begin
                        r_buf1 <= i_data;
                    end
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf0 <= i_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_out      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out <= 1'b1;
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= r_buf0;
                        r_par   <= w_head_par;
                        r_cnt   <= RELOAD;
                        r_out   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_cnt     <= RELOAD;
                        r_bit_idx <= 3'd0;
                        r_out     <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_stop_idx <= 1'b0;
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_out   <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_out   <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_out     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_cnt      <= RELOAD;
                        r_stop_idx <= 1'b0;
                        r_out      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (!w_last_stop) begin
                            r_stop_idx <= 1'b1;
                            r_cnt      <= RELOAD;
                        end else if (w_pop) begin
                            // Next frame starts on the same edge the stop interval ends.
                            r_state <= S_START;
                            r_shift <= r_buf0;
                            r_par   <= w_head_par;
                            r_cnt   <= RELOAD;
                            r_out   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_out   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= 1'b1;
                end
            endcase
        end
    end

    assign o_out   = r_out;
    assign o_ready = r_ready;
    assign o_busy  = (r_state != S_IDLE) || (r_count != 2'd0);

endmodule

// File: tb/tb_p16_uart_serializer.sv
// tb/tb_p16_uart_serializer.sv - directed bench for p16_uart_serializer at DIV=4.
module tb_p16_uart_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic [3:0] vld;
    wire  [3:0] rdy;
    wire  [3:0] sout;
    wire  [3:0] bsy;

    int   checks;
    int   errors;
    logic samp  [0:255];
    logic bsamp [0:255];

    always #5 clk = ~clk;

    // Instance 0: no parity, 1 stop; 1: even; 2: odd; 3: no parity, 2 stop bits.
    p16_uart_serializer #(.CLK_FREQ(38400), .BAUD(9600), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(vld[0]),
        .o_ready(rdy[0]), .o_out(sout[0]), .o_busy(bsy[0]));
    p16_uart_serializer #(.CLK_FREQ(38400), .BAUD(9600), .PARITY(1), .STOP_BITS(1)) u_pe (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(vld[1]),
        .o_ready(rdy[1]), .o_out(sout[1]), .o_busy(bsy[1]));
    p16_uart_serializer #(.CLK_FREQ(38400), .BAUD(9600), .PARITY(2), .STOP_BITS(1)) u_po (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(vld[2]),
        .o_ready(rdy[2]), .o_out(sout[2]), .o_busy(bsy[2]));
    p16_uart_serializer #(.CLK_FREQ(38400), .BAUD(9600), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(vld[3]),
        .o_ready(rdy[3]), .o_out(sout[3]), .o_busy(bsy[3]));

    function automatic logic [9:0] frame8(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int idx, input logic [7:0] d);
        int w;
        w = 0;
        din = d;
        vld[idx] = 1'b1;
        while (rdy[idx] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 200) begin
            errors++;
            $display("FAIL push_timeout inst %0d: ready never seen, got %b expected 1", idx, rdy[idx]);
        end
        @(negedge clk);
        vld[idx] = 1'b0;
    endtask

    task automatic collect(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            samp[i]  = sout[idx];
            bsamp[i] = bsy[idx];
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sout[i] !== 1'b1) begin errors++; $display("FAIL reset_out inst %0d: got %b expected 1", i, sout[i]); end
            checks++;
            if (rdy[i] !== 1'b0) begin errors++; $display("FAIL reset_ready inst %0d: got %b expected 0", i, rdy[i]); end
            checks++;
            if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d: got %b expected 0", i, bsy[i]); end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy !== 4'h0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0000", rdy); end
        @(negedge clk);
        checks++;
        if (rdy !== 4'hF) begin errors++; $display("FAIL ready_after_edge: got %b expected 1111", rdy); end
        checks++;
        if (sout !== 4'hF || bsy !== 4'h0) begin
            errors++; $display("FAIL idle_after_reset: out %b busy %b expected 1111 0000", sout, bsy);
        end
    endtask

    task automatic test_single_frame;
        logic [9:0] exp;
        exp = 10'b1010101010;
        push(0, 8'h55);
        checks++;
        if (sout[0] !== 1'b1 || bsy[0] !== 1'b1) begin
            errors++; $display("FAIL latency_edge_n: out %b busy %b expected 1 1", sout[0], bsy[0]);
        end
        @(negedge clk);
        collect(0, 40);
        for (int b = 0; b < 10; b++) begin
            logic ok;
            ok = 1'b1;
            for (int s = 0; s < 4; s++) if (samp[4*b+s] !== exp[b]) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL frame55_cell%0d: got %b%b%b%b expected %b x4", b,
                         samp[4*b], samp[4*b+1], samp[4*b+2], samp[4*b+3], exp[b]);
            end
        end
        checks++;
        if (bsamp[39] !== 1'b1 || bsy[0] !== 1'b0 || sout[0] !== 1'b1) begin
            errors++; $display("FAIL frame55_end: busy_last %b busy_now %b out %b expected 1 0 1", bsamp[39], bsy[0], sout[0]);
        end
    endtask

    task automatic test_parity;
        logic [10:0] exp_even;
        logic [10:0] exp_odd;
        exp_even = 11'b11000001110;
        exp_odd  = 11'b10000001110;
        for (int inst = 1; inst <= 2; inst++) begin
            logic [10:0] exp;
            exp = (inst == 1) ? exp_even : exp_odd;
            push(inst, 8'h07);
            @(negedge clk);
            collect(inst, 44);
            for (int b = 0; b < 11; b++) begin
                logic ok;
                ok = 1'b1;
                for (int s = 0; s < 4; s++) if (samp[4*b+s] !== exp[b]) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL parity_inst%0d_cell%0d: got %b%b%b%b expected %b x4", inst, b,
                             samp[4*b], samp[4*b+1], samp[4*b+2], samp[4*b+3], exp[b]);
                end
            end
            checks++;
            if (bsamp[43] !== 1'b1 || bsy[inst] !== 1'b0) begin
                errors++; $display("FAIL parity_inst%0d_len: busy_last %b busy_now %b expected 1 0", inst, bsamp[43], bsy[inst]);
            end
        end
    endtask

    task automatic test_stop_bits;
        logic [11:0] exp;
        exp = 12'b011111111110;
        push(3, 8'hFF);
        push(3, 8'h00);
        collect(3, 48);
        for (int b = 0; b < 12; b++) begin
            logic ok;
            ok = 1'b1;
            for (int s = 0; s < 4; s++) if (samp[4*b+s] !== exp[b]) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stop2_cell%0d: got %b%b%b%b expected %b x4", b,
                         samp[4*b], samp[4*b+1], samp[4*b+2], samp[4*b+3], exp[b]);
            end
        end
        repeat (50) @(negedge clk);
        checks++;
        if (bsy[3] !== 1'b0) begin errors++; $display("FAIL stop2_done: busy got %b expected 0", bsy[3]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [0:3];
        int         acc   [0:3];
        int         k;
        logic       r;
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43; bytes[3] = 8'h44;
        for (int i = 0; i < 4; i++) acc[i] = -1;
        k = 0;
        for (int t = 0; t < 170; t++) begin
            if (k < 4) begin
                vld[0] = 1'b1;
                din = bytes[k];
            end else begin
                vld[0] = 1'b0;
            end
            r = rdy[0];
            samp[t]  = sout[0];
            bsamp[t] = bsy[0];
            @(posedge clk);
            if (k < 4 && r === 1'b1) begin
                acc[k] = t;
                k++;
            end
            @(negedge clk);
        end
        vld[0] = 1'b0;
        checks++;
        if (acc[0] !== 0 || acc[1] !== 1 || acc[2] !== 2) begin
            errors++; $display("FAIL b2b_accept_first3: got %0d %0d %0d expected 0 1 2", acc[0], acc[1], acc[2]);
        end
        checks++;
        if (acc[3] !== 42) begin errors++; $display("FAIL b2b_accept_44: got %0d expected 42", acc[3]); end
        for (int f = 0; f < 4; f++) begin
            logic [9:0] exp;
            exp = frame8(bytes[f]);
            for (int b = 0; b < 10; b++) begin
                logic ok;
                ok = 1'b1;
                for (int s = 0; s < 4; s++) if (samp[2 + 40*f + 4*b + s] !== exp[b]) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL b2b_frame%0d_cell%0d: expected %b x4", f, b, exp[b]);
                end
            end
        end
        checks++;
        if (bsamp[161] !== 1'b1 || bsamp[162] !== 1'b0 || samp[162] !== 1'b1) begin
            errors++; $display("FAIL b2b_end: busy %b->%b out %b expected 1->0 1", bsamp[161], bsamp[162], samp[162]);
        end
    endtask

    task automatic test_data_hold;
        logic [9:0] exp;
        exp = 10'b1001111000;
        push(0, 8'h3C);
        din = 8'($urandom);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            samp[i] = sout[0];
            din = 8'($urandom);
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) begin
            logic ok;
            ok = 1'b1;
            for (int s = 0; s < 4; s++) if (samp[4*b+s] !== exp[b]) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL hold3c_cell%0d: got %b%b%b%b expected %b x4", b,
                         samp[4*b], samp[4*b+1], samp[4*b+2], samp[4*b+3], exp[b]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int bad;
        push(0, 8'hA5);
        push(0, 8'h5A);
        repeat (17) @(negedge clk);
        checks++;
        if (sout[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            errors++; $display("FAIL midframe_bit3: out %b busy %b expected 0 1", sout[0], bsy[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sout[0] !== 1'b1 || rdy[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            errors++; $display("FAIL async_reset: out %b ready %b busy %b expected 1 0 0", sout[0], rdy[0], bsy[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sout[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad); end
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", rdy[0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        din    = 8'h00;
        vld    = 4'h0;
        test_reset;
        test_single_frame;
        test_parity;
        test_stop_bits;
        test_back_to_back;
        test_data_hold;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p16_uart_serializer.md
P16_UART_SERIALIZER -- requirements
Module: p16_uart_serializer

Interface
REQ-001 The block SHALL take parameter CLK_FREQ, default 250000, meaning the clock frequency in Hz.
REQ-002 The block SHALL take parameter BAUD, default 9600, meaning the line rate in bits/s; DIV = CLK_FREQ/BAUD (integer division); elaboration SHALL fail if DIV < 2.
REQ-003 The block SHALL take parameter PARITY, default 0, meaning 0=none, 1=even, 2=odd.
REQ-004 The block SHALL take parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 and 2).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_data, input, 8 bits: byte to transmit.
REQ-008 The block SHALL have port i_valid, input, 1 bit: i_data is offered this cycle.
REQ-009 The block SHALL have port o_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-010 The block SHALL have port o_out, output, 1 bit: serial line, registered, idle high.
REQ-011 The block SHALL have port o_busy, output, 1 bit: a frame is in progress or a byte is buffered.

Function
REQ-012 The block SHALL hold a 2-entry in-order input buffer; o_ready = (entries < 2), from registered state only.
REQ-013 A byte SHALL be accepted on a rising edge where i_valid && o_ready; i_valid while o_ready=0 SHALL be ignored (no drop counting, no overwrite).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: o_out=1; if the buffer is non-empty, pop the head, load the shift register, go to START on that edge.
REQ-016 START: o_out=0 for DIV cycles, then go to DATA.
REQ-017 DATA: 8 bits, LSB first, each DIV cycles; after bit 7, go to PARITY if PARITY!=0, else STOP.
REQ-018 PARITY: o_out = XOR of the 8 data bits (even) or its inverse (odd), for DIV cycles; then go to STOP.
REQ-019 STOP: o_out=1 for STOP_BITS*DIV cycles; at the end, if the buffer is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
REQ-020 Bit timing SHALL use one down-counter reloaded to DIV-1 at every bit boundary; every bit SHALL last exactly DIV cycles.
REQ-021 Latency: for a byte accepted at edge N with the FSM in IDLE and the buffer empty, o_out SHALL go low after edge N+1.
REQ-022 Simultaneous push and pop SHALL be legal: the entry count is unchanged, order is preserved, and the pushed byte lands behind any remaining entry.
REQ-023 A push when the buffer holds 2 entries SHALL be impossible, because o_ready=0 even if a pop occurs in that cycle.
REQ-024 o_busy SHALL equal (state != IDLE) || (entries != 0).
REQ-025 i_data SHALL be sampled only at acceptance; later changes to i_data SHALL NOT affect a queued or in-flight frame.

Reset
REQ-026 While i_rst_n=0, outputs SHALL be o_out=1, o_ready=0, o_busy=0; state=IDLE, buffer empty, counters zero.
REQ-027 Assertion of i_rst_n SHALL take effect immediately and asynchronously, even mid-frame; the partial frame and buffered bytes SHALL be discarded.
REQ-028 On the first rising edge after i_rst_n deasserts, o_ready SHALL rise to 1.

Verification (bench: CLK_FREQ=38400, BAUD=9600, so DIV=4)
REQ-029 PARITY=0: push 0x55 -> o_out = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles (40 cycles total), then idle high, o_busy drops.
REQ-030 PARITY=1, push 0x07 -> parity bit 1; PARITY=2, push 0x07 -> parity bit 0; frame length 44 cycles.
REQ-031 Push 0x41, 0x42, 0x43, 0x44 with i_valid held high -> 0x41 starts at once; 0x42 and 0x43 are buffered; o_ready=0 until 0x41's stop bit ends; 0x44 is accepted only then; four frames are sent back-to-back in order with no idle gap.
REQ-032 STOP_BITS=2, push 0xFF -> start low for 4 cycles, then 8 data bits plus stop high; next byte's start bit begins exactly 12 cycles after bit 7 begins... no: after bit 7 ends, the stop interval lasts 8 cycles before the next start bit.
REQ-033 Assert i_rst_n=0 during DATA bit 3 of 0xA5 with 1 byte buffered -> o_out=1 immediately; after release, o_busy=0, nothing is transmitted.
REQ-034 Change i_data every cycle after accepting 0x3C -> serialized bits match 0x3C.
